div_ctrl: RTL and testbench
===========================

# div_ctrl

Sequencing controller for the 33-step signed restoring divider in the multi-cycle MIPS datapath. It accepts a DIV request from the main control FSM and latches and holds the operands for the divider's whole run. It issues the one-cycle start, tracks the divider's fixed latency and detects divide-by-zero. It owns the architectural Hi/Lo registers, which are also written by MTHI/MTLO and read by MFHI/MFLO.

## Interface
- DIV_CYCLES, 33: compute edges the divider needs after the start edge.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- op_req  in  1  DIV request, sampled only in IDLE.
- op_a  in  32  dividend, signed.
- op_b  in  32  divisor, signed.
- hi_wr  in  1  MTHI strobe.
- lo_wr  in  1  MTLO strobe.
- wr_data  in  32  MTHI/MTLO data.
- busy  out  1  high while a division is in flight.
- done  out  1  one-cycle pulse: Hi/Lo hold the new result.
- div_zero_exc  out  1  one-cycle pulse: divisor was zero, Hi/Lo unchanged.
- hi  out  32  architectural Hi (remainder).
- lo  out  32  architectural Lo (quotient).
- div_start  out  1  start pulse to the divider.
- div_dividend  out  32  held dividend to the divider.
- div_divisor  out  32  held divisor to the divider.
- div_hi  in  32  divider remainder.
- div_lo  in  32  divider quotient.
- div_divzero  in  1  divider divide-by-zero flag, valid the cycle after its start edge.

## Operation
- Reset value of every output and register is 0: state IDLE, cnt 0, operand registers 0, hi, lo, busy, done, div_zero_exc, div_start.
  - Zero operands during reset make the divider flag divzero; the controller ignores this.
- IDLE: busy=0. If op_req=1, latch op_a and op_b into the operand registers and go to START.
- START: div_start=1 (decoded from state); load cnt=DIV_CYCLES; go to RUN.
- RUN, first cycle:
  - div_divzero=1: go to IDLE and pulse div_zero_exc.
  - Otherwise each edge decrements cnt.
  - The edge where cnt==1 moves to CAPTURE.
- CAPTURE: the edge latches hi<=div_hi and lo<=div_lo, sets done for one cycle and goes to IDLE.
- div_dividend and div_divisor come straight from the operand registers.
  - They stay constant from START through CAPTURE, because the divider re-reads them for its final sign fix.
- busy = state != IDLE.
- op_req while busy is ignored; the requester must wait for busy=0.
- hi_wr/lo_wr in IDLE write wr_data on that edge.
  - op_req in the same IDLE cycle still starts the division.
  - The later capture overwrites both registers.
- hi_wr/lo_wr while busy are dropped and leave no effect.
- hi_wr and lo_wr together write both registers.
- Reset mid-operation returns to IDLE on that edge with all outputs 0; no done or exception is issued.

## Timing
- Edge T0 samples op_req; START occupies cycle T0–T1.
- div_start is high only during that cycle.
- RUN spans T1–T34, which is DIV_CYCLES edges.
- CAPTURE is T34–T35.
- done, new hi/lo and busy=0 are all visible in the cycle after T35: latency DIV_CYCLES+2 edges from the request edge.
- Divide-by-zero, macro off: div_zero_exc is high in the cycle after T2 and busy=0 there.
- Back-to-back: op_req may be high in the done cycle; the next START follows immediately.

## Configuration
- DIV_CTRL_ZERO_BYPASS_EN defined:
  - In IDLE, op_req with op_b==0 goes directly to IDLE; the divider is not started and no operands are latched.
  - div_zero_exc pulses in the cycle after T0, and busy never rises.
  - div_divzero is ignored.
- DIV_CTRL_ZERO_BYPASS_EN undefined: the divider is always started; divide-by-zero is detected from div_divzero in the first RUN cycle.

## Test plan
- 100 / 7 → lo=14, hi=2.
  - done is high exactly 35 cycles after the request edge.
  - div_start is high for exactly 1 cycle.
  - Operands are stable for the whole run.
- -100 / 7 → lo=0xFFFFFFF2, hi=0xFFFFFFFE.
- 100 / -7 → lo=0xFFFFFFF2, hi=2.
- MTHI 0x1234, then 5 / 0 → div_zero_exc pulse and hi=0x1234, lo unchanged.
  - The pulse appears at cycle T0+1 with the macro, T2+1 without it.
- Division 100 / 7 running; op_req (op_a=9, op_b=3) and hi_wr (0xDEAD) at cycle 10 → both ignored.
  - Result is lo=14, hi=2, and only one done pulse occurs.
- Reset asserted at RUN cycle 10 → all outputs 0 on the next cycle.
  - A following 50 / 5 then gives lo=10, hi=0 with the nominal latency.

Source files
------------

// File: rtl/div_ctrl.sv
// div_ctrl: sequencing controller for the 33-step signed divider.
// Owns Hi/Lo. Optional macro: DIV_CTRL_ZERO_BYPASS_EN (skip divider on /0).
module div_ctrl #(
    parameter int DIV_CYCLES = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_req,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        hi_wr,
    input  logic        lo_wr,
    input  logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        div_zero_exc,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_start,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    input  logic        div_divzero
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        RUN     = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    localparam logic [5:0] CNT_LOAD = 6'(DIV_CYCLES);

    state_t      state;
    state_t      state_d;
    logic [5:0]  cnt;
    logic [5:0]  cnt_d;
    logic [31:0] opa_q;
    logic [31:0] opa_d;
    logic [31:0] opb_q;
    logic [31:0] opb_d;
    logic [31:0] hi_q;
    logic [31:0] hi_d;
    logic [31:0] lo_q;
    logic [31:0] lo_d;
    logic        done_q;
    logic        done_d;
    logic        exc_q;
    logic        exc_d;

    // State, counter, held operands, Hi/Lo and pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            exc_q  <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            opa_q  <= opa_d;
            opb_q  <= opb_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= done_d;
            exc_q  <= exc_d;
        end
    end

    // Next-state and register updates; pulses default low each cycle.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        opa_d   = opa_q;
        opb_d   = opb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        exc_d   = 1'b0;
        unique case (state)
            IDLE: begin
                // MTHI/MTLO only land while no division is in flight.
                if (hi_wr) begin
                    hi_d = wr_data;
                end
                if (lo_wr) begin
                    lo_d = wr_data;
                end
                if (op_req) begin
`ifdef DIV_CTRL_ZERO_BYPASS_EN
                    if (op_b == 32'd0) begin
                        exc_d = 1'b1;
                    end else begin
                        opa_d   = op_a;
                        opb_d   = op_b;
                        state_d = START;
                    end
`else
                    opa_d   = op_a;
                    opb_d   = op_b;
                    state_d = START;
`endif
                end
            end
            START: begin
                cnt_d   = CNT_LOAD;
                state_d = RUN;
            end
            RUN: begin
`ifndef DIV_CTRL_ZERO_BYPASS_EN
                // The divider's zero flag is only meaningful right after start.
                if ((cnt == CNT_LOAD) && div_divzero) begin
                    cnt_d   = '0;
                    exc_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt - 6'd1;
                    if (cnt == 6'd1) begin
                        state_d = CAPTURE;
                    end
                end
`else
                cnt_d = cnt - 6'd1;
                if (cnt == 6'd1) begin
                    state_d = CAPTURE;
                end
`endif
            end
            CAPTURE: begin
                hi_d    = div_hi;
                lo_d    = div_lo;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy         = (state != IDLE);
    assign div_start    = (state == START);
    assign done         = done_q;
    assign div_zero_exc = exc_q;
    assign hi           = hi_q;
    assign lo           = lo_q;
    assign div_dividend = opa_q;
    assign div_divisor  = opb_q;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: randomized self-checking bench for div_ctrl.
// Models the divider as a fixed-latency black box.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_req = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        hi_wr = 1'b0;
    logic        lo_wr = 1'b0;
    logic [31:0] wr_data = '0;
    logic        busy;
    logic        done;
    logic        div_zero_exc;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_start;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    logic        div_divzero;

    int n_checks = 0;
    int n_fail = 0;

`ifdef DIV_CTRL_ZERO_BYPASS_EN
    localparam int EXC_LAT = 0;
    localparam int EXC_STARTS = 0;
`else
    localparam int EXC_LAT = 2;
    localparam int EXC_STARTS = 1;
`endif
    localparam int LAT = 35;

    always #5 clk = ~clk;

    div_ctrl #(.DIV_CYCLES(33)) dut (
        .clk(clk),
        .reset(reset),
        .op_req(op_req),
        .op_a(op_a),
        .op_b(op_b),
        .hi_wr(hi_wr),
        .lo_wr(lo_wr),
        .wr_data(wr_data),
        .busy(busy),
        .done(done),
        .div_zero_exc(div_zero_exc),
        .hi(hi),
        .lo(lo),
        .div_start(div_start),
        .div_dividend(div_dividend),
        .div_divisor(div_divisor),
        .div_hi(div_hi),
        .div_lo(div_lo),
        .div_divzero(div_divzero)
    );

    function automatic logic [31:0] ref_q(input logic [31:0] a, input logic [31:0] b);
        ref_q = 32'($signed(a) / $signed(b));
    endfunction

    function automatic logic [31:0] ref_r(input logic [31:0] a, input logic [31:0] b);
        ref_r = 32'($signed(a) % $signed(b));
    endfunction

    // Divider stand-in: result valid 33 edges after start, re-reading live operands.
    logic [31:0] m_b = '0;
    int m_cnt = 100;
    always @(posedge clk) begin
        if (div_start) begin
            m_b   <= div_divisor;
            m_cnt <= 0;
        end else if (m_cnt < 100) begin
            m_cnt <= m_cnt + 1;
        end
    end
    assign div_divzero = (m_b == 32'd0);
    always_comb begin
        div_lo = 32'hBAD0BAD0;
        div_hi = 32'h0BAD0BAD;
        if (m_cnt >= 33 && div_divisor != 32'd0) begin
            div_lo = ref_q(div_dividend, div_divisor);
            div_hi = ref_r(div_dividend, div_divisor);
        end
    end

    // Event monitor: pulse counts and operand stability while busy.
    int done_cnt = 0;
    int exc_cnt = 0;
    int start_cnt = 0;
    int unstable_cnt = 0;
    logic [31:0] snap_a = '0;
    logic [31:0] snap_b = '0;
    always @(negedge clk) begin
        #2;
        if (done) done_cnt <= done_cnt + 1;
        if (div_zero_exc) exc_cnt <= exc_cnt + 1;
        if (div_start) begin
            start_cnt <= start_cnt + 1;
            snap_a <= div_dividend;
            snap_b <= div_divisor;
        end else if (busy && (div_dividend !== snap_a || div_divisor !== snap_b)) begin
            unstable_cnt <= unstable_cnt + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required<400000", $time);
        $fatal(1);
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        op_a = a;
        op_b = b;
        op_req = 1'b1;
        @(posedge clk);
        #1;
        op_req = 1'b0;
    endtask

    task automatic wait_event(output int lat_done, output int lat_exc, output logic busy_at);
        lat_done = -1;
        lat_exc = -1;
        busy_at = 1'b1;
        for (int k = 0; k <= 50; k++) begin
            @(negedge clk);
            if (done && lat_done < 0) begin
                lat_done = k;
                busy_at = busy;
            end
            if (div_zero_exc && lat_exc < 0) begin
                lat_exc = k;
                busy_at = busy;
            end
            if (lat_done >= 0 || lat_exc >= 0) break;
        end
    endtask

    task automatic test_reset();
        int e0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, div_zero_exc, div_start} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 0000", {busy, done, div_zero_exc, div_start});
        end
        n_checks++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_hilo: hi=%h lo=%h required 0", hi, lo);
        end
        n_checks++;
        if (div_dividend !== 32'd0 || div_divisor !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_ops: %h %h required 0", div_dividend, div_divisor);
        end
        reset = 1'b0;
        e0 = exc_cnt;
        repeat (5) @(negedge clk);
        n_checks++;
        if (exc_cnt - e0 !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: exc=%0d busy=%b required 0 0", exc_cnt - e0, busy);
        end
    endtask

    task automatic test_basic();
        int ld, le, s0, d0, u0;
        logic b;
        s0 = start_cnt;
        d0 = done_cnt;
        u0 = unstable_cnt;
        issue(32'd100, 32'd7);
        wait_event(ld, le, b);
        n_checks++;
        if (ld !== LAT) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d required %0d", ld, LAT);
        end
        n_checks++;
        if (lo !== 32'd14 || hi !== 32'd2) begin
            n_fail++;
            $display("FAIL basic_result: lo=%h hi=%h required e 2", lo, hi);
        end
        n_checks++;
        if (b !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy: got %b required 0", b);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (start_cnt - s0 !== 1) begin
            n_fail++;
            $display("FAIL basic_start: %0d cycles required 1", start_cnt - s0);
        end
        n_checks++;
        if (done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL basic_done_pulse: %0d cycles required 1", done_cnt - d0);
        end
        n_checks++;
        if (unstable_cnt - u0 !== 0) begin
            n_fail++;
            $display("FAIL basic_stable: %0d changes required 0", unstable_cnt - u0);
        end
    endtask

    task automatic test_signs();
        logic [31:0] ta[3] = '{32'hFFFFFF9C, 32'd100, 32'hFFFFFF9C};
        logic [31:0] tb[3] = '{32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9};
        logic [31:0] eq[3] = '{32'hFFFFFFF2, 32'hFFFFFFF2, 32'd14};
        logic [31:0] er[3] = '{32'hFFFFFFFE, 32'd2, 32'hFFFFFFFE};
        int ld, le;
        logic b;
        for (int i = 0; i < 3; i++) begin
            issue(ta[i], tb[i]);
            wait_event(ld, le, b);
            n_checks++;
            if (ld !== LAT || lo !== eq[i] || hi !== er[i]) begin
                n_fail++;
                $display("FAIL signs_%0d: lat=%0d lo=%h hi=%h required %0d %h %h",
                         i, ld, lo, hi, LAT, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_mt_same_cycle();
        int ld, le;
        logic b;
        wr_data = 32'hCAFE0001;
        hi_wr = 1'b1;
        lo_wr = 1'b1;
        issue(32'd40, 32'd6);
        hi_wr = 1'b0;
        lo_wr = 1'b0;
        @(negedge clk);
        n_checks++;
        if (hi !== 32'hCAFE0001 || lo !== 32'hCAFE0001 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mt_write: hi=%h lo=%h busy=%b required cafe0001 cafe0001 1", hi, lo, busy);
        end
        wait_event(ld, le, b);
        n_checks++;
        if (ld !== LAT - 1 || lo !== 32'd6 || hi !== 32'd4) begin
            n_fail++;
            $display("FAIL mt_overwrite: lat=%0d lo=%h hi=%h required %0d 6 4", ld + 1, lo, hi, LAT);
        end
    endtask

    task automatic test_divzero();
        int ld, le, s0, d0;
        logic b;
        wr_data = 32'h000055AA;
        lo_wr = 1'b1;
        @(posedge clk);
        #1;
        lo_wr = 1'b0;
        wr_data = 32'h00001234;
        hi_wr = 1'b1;
        @(posedge clk);
        #1;
        hi_wr = 1'b0;
        @(negedge clk);
        s0 = start_cnt;
        d0 = done_cnt;
        issue(32'd5, 32'd0);
        wait_event(ld, le, b);
        n_checks++;
        if (le !== EXC_LAT || b !== 1'b0) begin
            n_fail++;
            $display("FAIL dz_timing: lat=%0d busy=%b required %0d 0", le, b, EXC_LAT);
        end
        n_checks++;
        if (hi !== 32'h1234 || lo !== 32'h55AA) begin
            n_fail++;
            $display("FAIL dz_hilo: hi=%h lo=%h required 1234 55aa", hi, lo);
        end
        @(negedge clk);
        n_checks++;
        if (div_zero_exc !== 1'b0) begin
            n_fail++;
            $display("FAIL dz_pulse: exc=%b required 0", div_zero_exc);
        end
        repeat (40) @(negedge clk);
        n_checks++;
        if (done_cnt - d0 !== 0 || start_cnt - s0 !== EXC_STARTS) begin
            n_fail++;
            $display("FAIL dz_side: done=%0d starts=%0d required 0 %0d",
                     done_cnt - d0, start_cnt - s0, EXC_STARTS);
        end
    endtask

    task automatic test_busy_ignore();
        int ld, d0, s0;
        wr_data = 32'h0000AAAA;
        hi_wr = 1'b1;
        @(posedge clk);
        #1;
        hi_wr = 1'b0;
        @(negedge clk);
        d0 = done_cnt;
        s0 = start_cnt;
        issue(32'd100, 32'd7);
        ld = -1;
        for (int k = 0; k <= 50; k++) begin
            @(negedge clk);
            if (k == 10) begin
                op_a = 32'd9;
                op_b = 32'd3;
                op_req = 1'b1;
                wr_data = 32'hDEAD;
                hi_wr = 1'b1;
            end
            if (k == 11) begin
                op_req = 1'b0;
                hi_wr = 1'b0;
            end
            if (k == 12) begin
                n_checks++;
                if (hi !== 32'h0000AAAA) begin
                    n_fail++;
                    $display("FAIL busy_hi_wr: hi=%h required 0000aaaa", hi);
                end
            end
            if (done) begin
                ld = k;
                break;
            end
        end
        n_checks++;
        if (ld !== LAT || lo !== 32'd14 || hi !== 32'd2) begin
            n_fail++;
            $display("FAIL busy_result: lat=%0d lo=%h hi=%h required %0d e 2", ld, lo, hi, LAT);
        end
        repeat (45) @(negedge clk);
        n_checks++;
        if (done_cnt - d0 !== 1 || start_cnt - s0 !== 1) begin
            n_fail++;
            $display("FAIL busy_single: done=%0d starts=%0d required 1 1", done_cnt - d0, start_cnt - s0);
        end
    endtask

    task automatic test_back_to_back();
        int ld, le;
        logic b;
        issue(32'd20, 32'd3);
        wait_event(ld, le, b);
        n_checks++;
        if (ld !== LAT || lo !== 32'd6 || hi !== 32'd2) begin
            n_fail++;
            $display("FAIL b2b_first: lat=%0d lo=%h hi=%h required %0d 6 2", ld, lo, hi, LAT);
        end
        issue(32'hFFFFFFCE, 32'd6);
        @(negedge clk);
        n_checks++;
        if (div_start !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_start: div_start=%b required 1", div_start);
        end
        wait_event(ld, le, b);
        n_checks++;
        if (ld !== LAT - 1 || lo !== 32'hFFFFFFF8 || hi !== 32'hFFFFFFFE) begin
            n_fail++;
            $display("FAIL b2b_second: lat=%0d lo=%h hi=%h required %0d fffffff8 fffffffe",
                     ld + 1, lo, hi, LAT);
        end
    endtask

    task automatic test_random();
        int ld, le;
        logic b;
        logic [31:0] a, d;
        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            d = 32'($urandom_range(1, 1000));
            if ($urandom_range(0, 1) == 1) d = -d;
            issue(a, d);
            wait_event(ld, le, b);
            n_checks++;
            if (ld !== LAT || lo !== ref_q(a, d) || hi !== ref_r(a, d)) begin
                n_fail++;
                $display("FAIL rand_%0d: %h/%h lat=%0d lo=%h hi=%h required %0d %h %h",
                         i, a, d, ld, lo, hi, LAT, ref_q(a, d), ref_r(a, d));
            end
        end
    endtask

    task automatic test_reset_mid();
        int ld, le, d0, e0;
        logic b;
        issue(32'd100, 32'd7);
        repeat (11) @(negedge clk);
        d0 = done_cnt;
        e0 = exc_cnt;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, done, div_zero_exc, div_start} !== 4'b0 || hi !== 32'd0 || lo !== 32'd0 ||
            div_dividend !== 32'd0 || div_divisor !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset: flags=%b hi=%h lo=%h ops=%h %h required all 0",
                     {busy, done, div_zero_exc, div_start}, hi, lo, div_dividend, div_divisor);
        end
        reset = 1'b0;
        repeat (30) @(negedge clk);
        n_checks++;
        if (done_cnt - d0 !== 0 || exc_cnt - e0 !== 0) begin
            n_fail++;
            $display("FAIL mid_no_pulse: done=%0d exc=%0d required 0 0", done_cnt - d0, exc_cnt - e0);
        end
        issue(32'd50, 32'd5);
        wait_event(ld, le, b);
        n_checks++;
        if (ld !== LAT || lo !== 32'd10 || hi !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_after: lat=%0d lo=%h hi=%h required %0d a 0", ld, lo, hi, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_mt_same_cycle();
        test_divzero();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
